hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_load_use.sv | 21 ++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline hazard types, state encodings and default cycle counts
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hz_ctrl_t;

    localparam int          DEF_INIT_CYCLES  = 4;
    localparam int          DEF_DRAIN_CYCLES = 4;
    localparam logic [15:0] CNT_MAX          = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// rtl/hazard_ctrl_load_use.sv - load-use comparator between the EX load and ID source registers
module load_use_detect (
    input  logic       ex_mem2reg,
    input  logic       ex_regwrite,
    input  logic [4:0] ex_dst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic hit_rs;
    logic hit_rt;

    // $0 is hardwired, so a non-zero destination also keeps ID reads of $0 from matching
    assign hit_rs   = id_uses_rs && (ex_dst == id_rs);
    assign hit_rt   = id_uses_rt && (ex_dst == id_rt);
    assign load_use = ex_mem2reg && ex_regwrite && (ex_dst != 5'd0) && (hit_rs || hit_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, flush and halt/drain control with performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [4:0]  ID_RSAddr,
    input  logic [4:0]  ID_RTAddr,
    input  logic        ID_UsesRS,
    input  logic        ID_UsesRT,
    input  logic        EX_Mem2RegSEL,
    input  logic        EX_RegWriteEN,
    input  logic [4:0]  EX_DstAddr,
    input  logic        BranchTaken,
    input  logic        HaltReq,
    input  logic        ResumeReq,
    output logic        PCWriteEN,
    output logic        IFID_WriteEN,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic [1:0]  State,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam logic [15:0] INIT_LOAD  = 16'(INIT_CYCLES);
    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES);

    hz_state_t   state_q;
    hz_state_t   state_d;
    logic [15:0] init_cnt;
    logic [15:0] drain_cnt;
    logic        load_use;
    logic        active;
    logic        stall_evt;
    logic        flush_evt;
    hz_ctrl_t    ctrl;

    load_use_detect u_load_use_detect (
        .ex_mem2reg  (EX_Mem2RegSEL),
        .ex_regwrite (EX_RegWriteEN),
        .ex_dst      (EX_DstAddr),
        .id_rs       (ID_RSAddr),
        .id_rt       (ID_RTAddr),
        .id_uses_rs  (ID_UsesRS),
        .id_uses_rt  (ID_UsesRT),
        .load_use    (load_use)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            init_cnt  <= INIT_LOAD;
            drain_cnt <= 16'd0;
        end else begin
            if (state_q == ST_INIT && init_cnt != 16'd0) begin
                init_cnt <= init_cnt - 16'd1;
            end
            if (state_q == ST_RUN && state_d == ST_DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state_q == ST_DRAIN && drain_cnt != 16'd0) begin
                drain_cnt <= drain_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (init_cnt <= 16'd1) state_d = ST_RUN;
            ST_RUN:    if (HaltReq && !BranchTaken) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt <= 16'd1) state_d = ST_HALTED;
            ST_HALTED: if (ResumeReq) state_d = ST_RUN;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
        case (state_q)
            ST_RUN: begin
                if (BranchTaken) begin
                    ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
                end else if (load_use) begin
                    ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};
                end else begin
                    ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
                end
            end
            ST_DRAIN: begin
                ctrl.pc_we       = BranchTaken;
                ctrl.ifid_we     = 1'b0;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = BranchTaken || load_use;
                ctrl.exmem_flush = BranchTaken;
            end
            default: ;
        endcase
    end

    // A branch flush swallows the stalled instruction, so it is not counted as a stall
    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign stall_evt = active && load_use && !BranchTaken;
    assign flush_evt = active && BranchTaken;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            if (stall_evt) StallCount <= sat_inc(StallCount);
            if (flush_evt) FlushCount <= sat_inc(FlushCount);
        end
    end

    assign State        = state_q;
    assign PCWriteEN    = ctrl.pc_we;
    assign IFID_WriteEN = ctrl.ifid_we;
    assign IFID_Flush   = ctrl.ifid_flush;
    assign IDEX_Flush   = ctrl.idex_flush;
    assign EXMEM_Flush  = ctrl.exmem_flush;

endmodule
